priority_encoder_4to2: RTL and testbench

PRIORITY_ENCODER_4TO2 -- requirements
Module: priority_encoder_4to2

---
 rtl/priority_encoder_4to2.sv | 47 ++++
 tb/tb_priority_encoder_4to2.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/priority_encoder_4to2.sv
// Registered 4-to-2 priority encoder: bit 3 wins. out/valid come straight from flops,
// one cycle after the request vector is sampled.
module priority_encoder_4to2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] in,
    output logic [1:0] out,
    output logic       valid
);

    // any_above[k] is set when any request at index k or higher is asserted
    logic [4:0] any_above;
    logic [3:0] grant;
    logic [1:0] out_d;
    logic [1:0] out_q;
    logic       valid_d;
    logic       valid_q;

    assign any_above[4] = 1'b0;

    generate
        for (genvar gi = 3; gi >= 0; gi--) begin : g_grant
            assign any_above[gi] = any_above[gi+1] | in[gi];
            assign grant[gi]     = in[gi] & ~any_above[gi+1];
        end
    endgenerate

    // grant is one-hot (or zero), so the index bits are simple ORs
    always_comb begin
        out_d   = {grant[3] | grant[2], grant[3] | grant[1]};
        valid_d = any_above[0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q   <= 2'b00;
            valid_q <= 1'b0;
        end else begin
            out_q   <= out_d;
            valid_q <= valid_d;
        end
    end

    assign out   = out_q;
    assign valid = valid_q;

endmodule

// File: tb/tb_priority_encoder_4to2.sv
// Self-checking bench for priority_encoder_4to2: directed reset/latency cases plus
// a full code sweep and random traffic against a behavioural reference.
module tb_priority_encoder_4to2;

    logic       clk;
    logic       rst_n;
    logic [3:0] in;
    logic [1:0] out;
    logic       valid;

    int tests;
    int fails;

    priority_encoder_4to2 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .in    (in),
        .out   (out),
        .valid (valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: the highest set bit index, found by scanning upward; {valid, out}
    function automatic logic [2:0] ref_enc(input logic [3:0] v);
        int idx;
        idx = 0;
        for (int i = 0; i < 4; i++)
            if (v[i]) idx = i;
        return {(v != 4'd0), 2'(idx)};
    endfunction

    task automatic chk(input string tag, input logic [2:0] expv);
        tests++;
        assert ({valid, out} === expv)
        else begin
            fails++;
            $error("FAIL %s: in=%b observed valid,out=%b required=%b", tag, in, {valid, out}, expv);
        end
    endtask

    // Apply v away from the active edge, then check one edge later
    task automatic step(input string tag, input logic [3:0] v);
        @(negedge clk);
        in = v;
        @(posedge clk);
        #1;
        chk(tag, ref_enc(v));
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin : stim
        logic [3:0] prev;
        logic [3:0] r;
        tests = 0;
        fails = 0;
        rst_n = 1'b1;
        in    = 4'b1000;

        // Reset with a request pending: cleared without any clock edge
        #1 rst_n = 1'b0;
        #1 chk("reset_async", 3'b000);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1 chk("reset_hold", 3'b000);
        end

        @(negedge clk);
        rst_n = 1'b1;
        in    = 4'b1000;
        @(posedge clk);
        #1 chk("first_edge_after_reset", 3'b111);

        // Single-bit requests and zero input
        step("single_0001", 4'b0001);
        chk("single_0001_exp", 3'b100);
        step("single_0010", 4'b0010);
        chk("single_0010_exp", 3'b101);
        step("single_0100", 4'b0100);
        chk("single_0100_exp", 3'b110);
        step("single_1000", 4'b1000);
        chk("single_1000_exp", 3'b111);
        step("zero_0000", 4'b0000);
        chk("zero_0000_exp", 3'b000);

        // Multi-bit requests: only the highest set bit counts
        step("multi_1110", 4'b1110);
        chk("multi_1110_exp", 3'b111);
        step("multi_0110", 4'b0110);
        chk("multi_0110_exp", 3'b110);
        step("multi_0011", 4'b0011);
        chk("multi_0011_exp", 3'b101);
        step("multi_1111", 4'b1111);
        chk("multi_1111_exp", 3'b111);

        // Latency/hold: a mid-cycle change is invisible until the next edge
        step("latency_pre", 4'b0001);
        @(negedge clk);
        in = 4'b1000;
        #2 chk("latency_hold", 3'b100);
        @(posedge clk);
        #1 chk("latency_update", 3'b111);

        // Reset pulse between edges while outputs are 11/1
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1 chk("midop_reset_clear", 3'b000);
        #1 rst_n = 1'b1;
        #1 chk("midop_reset_released", 3'b000);
        @(posedge clk);
        #1 chk("midop_reset_recover", 3'b111);

        // Sweep of all 16 codes
        for (int c = 0; c < 16; c++)
            step("sweep", 4'(c));

        // Random traffic, with a random glitch on in between edges
        prev = in;
        for (int k = 0; k < 60; k++) begin
            r = 4'($urandom_range(0, 15));
            @(negedge clk);
            in = r;
            #2 in = 4'($urandom_range(0, 15));
            #1 chk("random_hold", ref_enc(prev));
            in = r;
            @(posedge clk);
            #1 chk("random", ref_enc(r));
            prev = r;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
